mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch requester and
//   a data (load/store) requester. Data normally wins. A saturating streak
//   counter forces a fetch grant after STARVE_LIMIT back-to-back data grants
//   taken while a fetch was waiting. Each transaction is bounded by a timeout
//   that completes it with zero data and resp_err set.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   if_req, if_addr      fetch request / address (held until if_valid)
//   if_rdata, if_valid   fetch data / one-cycle completion pulse
//   d_req, d_we          data request, 1=store 0=load (held until d_valid)
//   d_addr, d_wdata      data address / store data
//   d_rdata, d_valid     load data / one-cycle completion pulse
//   resp_err             qualifies a completion pulse as a timeout
//   stall_if, stall_d    requester stalls (combinational)
//   mem_req, mem_we      registered memory request / write enable
//   mem_addr, mem_wdata  registered memory address / write data
//   mem_rdata, mem_ack   memory read data / one-cycle completion
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        resp_err,
  output logic        stall_if,
  output logic        stall_d,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] wait_cnt;

  logic grant_d, grant_if, busy, done_ack, done_to;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment at the top keeps every path assigned so no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_d)       state_nxt = BUSY_D;
               else if (grant_if) state_nxt = BUSY_IF;
      BUSY_IF,
      BUSY_D:  if (done_ack || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/decode logic: grant arbitration, completion detection, stalls.
  // Data wins unless a fetch has waited through STARVE_LIMIT data grants.
  // An ack in the final timeout cycle takes precedence over the timeout.
  always_comb begin
    busy     = (state == BUSY_IF) || (state == BUSY_D);
    grant_d  = (state == IDLE) && d_req &&
               !(if_req && (streak == SW'(STARVE_LIMIT)));
    grant_if = (state == IDLE) && if_req && !grant_d;
    done_ack = busy && mem_ack;
    done_to  = busy && !mem_ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));
    stall_if = if_req & ~if_valid;
    stall_d  = d_req & ~d_valid;
  end

  // Registered datapath. Completion pulses default low, so they last
  // exactly the single RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      resp_err  <= 1'b0;
      streak    <= '0;
      wait_cnt  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      resp_err <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        wait_cnt  <= '0;
        // Only data grants that overtake a waiting fetch count toward starvation.
        if (if_req && (streak != SW'(STARVE_LIMIT))) streak <= streak + 1'b1;
      end else if (grant_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        wait_cnt <= '0;
        streak   <= '0;
      end else if (done_ack) begin
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end else begin
          // Stores complete without disturbing the last load result.
          if (!mem_we) d_rdata <= mem_rdata;
          d_valid <= 1'b1;
        end
      end else if (done_to) begin
        mem_req  <= 1'b0;
        resp_err <= 1'b1;
        if (state == BUSY_IF) begin
          if_rdata <= '0;
          if_valid <= 1'b1;
        end else begin
          d_rdata <= '0;
          d_valid <= 1'b1;
        end
      end else if (busy) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge; the memory side is a per-transaction
// ack task with a chosen latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        resp_err;
  logic        stall_if;
  logic        stall_d;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .resp_err  (resp_err),
    .stall_if  (stall_if),
    .stall_d   (stall_d),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for mem_req; returns on the falling edge where it is seen.
  task automatic wait_req(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  // Called on the falling edge where mem_req is first seen (BUSY cycle 1).
  // Acks in BUSY cycle n and returns on the falling edge of the RESP cycle.
  task automatic do_ack(input int n, input logic [15:0] data);
    repeat (n - 1) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  initial begin
    int busy_cycles;
    bit saw_dvalid;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_valids", {if_valid, d_valid, resp_err}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;

    // ---- Single fetch, ack two cycles after mem_req ----
    if_req = 1'b1; if_addr = 16'h0010;
    wait_req("f_req_wait", 5);
    check("f_addr", mem_addr, 16'h0010);
    check("f_we", mem_we, 0);
    check("f_stall", stall_if, 1);
    do_ack(2, 16'hA5A5);
    check("f_valid", {if_valid, d_valid}, 2'b10);
    check("f_rdata", if_rdata, 16'hA5A5);
    check("f_err", resp_err, 0);
    check("f_req_drop", mem_req, 0);
    check("f_stall_resp", stall_if, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_valid_end", if_valid, 0);

    // ---- Load, ack three cycles after mem_req ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    wait_req("ld_req_wait", 5);
    check("ld_addr_we", {mem_addr, 15'h0, mem_we}, {16'h0300, 16'h0000});
    do_ack(3, 16'h0BEE);
    check("ld_valid", {if_valid, d_valid, resp_err}, 3'b010);
    check("ld_rdata", d_rdata, 16'h0BEE);
    check("ld_stall_d", stall_d, 0);
    d_req = 1'b0;
    @(negedge clk);

    // ---- Simultaneous store and fetch: store first ----
    if_req = 1'b1; if_addr = 16'h0040;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    wait_req("sim_req_wait", 5);
    check("sim_st_we", mem_we, 1);
    check("sim_st_addr", mem_addr, 16'h0200);
    check("sim_st_wdata", mem_wdata, 16'h1234);
    check("sim_stall_if", stall_if, 1);
    do_ack(2, 16'hDEAD);
    check("sim_st_valid", {if_valid, d_valid}, 2'b01);
    check("sim_st_rdata_kept", d_rdata, 16'h0BEE);
    check("sim_stall_if_resp", stall_if, 1);
    d_req = 1'b0; d_we = 1'b0;
    wait_req("sim_f_wait", 5);
    check("sim_f_addr_we", {mem_addr, 15'h0, mem_we}, {16'h0040, 16'h0000});
    do_ack(1, 16'h5555);
    check("sim_f_valid", {if_valid, d_valid}, 2'b10);
    check("sim_f_rdata", if_rdata, 16'h5555);
    if_req = 1'b0;
    @(negedge clk);

    // ---- Starvation: 4 data grants, then fetch, then data again ----
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    for (int g = 0; g < 6; g++) begin
      wait_req($sformatf("stv_wait%0d", g), 5);
      check($sformatf("stv_addr%0d", g), mem_addr, (g == 4) ? 16'h0100 : 16'h0400);
      do_ack(1, 16'h7000 + 16'(g));
      check($sformatf("stv_valid%0d", g), {if_valid, d_valid}, (g == 4) ? 2'b10 : 2'b01);
      if (g == 5) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    check("stv_rdata", {if_rdata, d_rdata}, {16'h7004, 16'h7005});
    @(negedge clk);

    // ---- Timeout on a load ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
    wait_req("to_req_wait", 5);
    busy_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      busy_cycles++;
    end
    check("to_busy_cycles", busy_cycles, 15);
    check("to_valid_err", {d_valid, resp_err}, 2'b11);
    check("to_rdata", d_rdata, 16'h0000);
    d_req = 1'b0;
    @(negedge clk);
    check("to_err_end", {d_valid, resp_err}, 2'b00);

    // ---- Ack in the 15th BUSY cycle beats the timeout ----
    d_req = 1'b1; d_addr = 16'h0600;
    wait_req("tie_req_wait", 5);
    do_ack(15, 16'hC0DE);
    check("tie_valid_err", {d_valid, resp_err}, 2'b10);
    check("tie_rdata", d_rdata, 16'hC0DE);
    d_req = 1'b0;
    @(negedge clk);

    // ---- Stray ack in IDLE is ignored ----
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check("stray_outs", {mem_req, if_valid, d_valid, resp_err}, 4'b0000);
    check("stray_rdata", {if_rdata, d_rdata}, {16'h7004, 16'hC0DE});

    // ---- Reset during BUSY_D ----
    d_req = 1'b1; d_addr = 16'h0700;
    wait_req("rst_req_wait", 5);
    #2 rst_n = 1'b0;
    #1 check("rst_async_mem_req", mem_req, 0);
    @(negedge clk);
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 16'h0800;
    rst_n = 1'b1;
    saw_dvalid = 1'b0;
    @(negedge clk);
    check("rst_first_grant", {mem_req, mem_addr}, {1'b1, 16'h0800});
    if (d_valid) saw_dvalid = 1'b1;
    do_ack(2, 16'h3C3C);
    if (d_valid) saw_dvalid = 1'b1;
    check("rst_f_valid", if_valid, 1);
    if_req = 1'b0;
    @(negedge clk);
    if (d_valid) saw_dvalid = 1'b1;
    check("rst_no_dvalid", saw_dvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
